// File: rtl/sensor_scan_mux.sv
// sensor_scan_mux: registered multiplexer over CHANNELS sensor inputs.
// Manual mode samples the channel named by sel on every enabled edge.
// Scan mode dwells DWELL cycles per channel and steps round-robin,
// flagging the end of each sweep with scan_done.
module sensor_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      enable,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          ch_out,
  output logic                      valid,
  output logic                      scan_done
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SLOTS = 1 << SEL_W;

  // Compare limits held at matching widths so every comparison is width-exact.
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_MAX  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CHAN_LIM = (SEL_W + 1)'(CHANNELS);

  // Channels unpacked into an array padded to a power of two, so any
  // SEL_W-bit index stays inside the array; padding slots read as zero.
  logic [WIDTH-1:0] chan [SLOTS];

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_real
        assign chan[gi] = in_bus[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  logic [SEL_W-1:0] ptr_reg,    ptr_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             mode_q_reg, mode_q_next;
  logic [WIDTH-1:0] data_reg,   data_next;
  logic [SEL_W-1:0] ch_reg,     ch_next;
  logic             valid_reg,  valid_next;
  logic             done_reg,   done_next;

  // Next-state: hold everything and drop the strobes unless an enabled edge
  // has something to do.
  always_comb begin
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    mode_q_next = mode_q_reg;
    data_next   = data_reg;
    ch_next     = ch_reg;
    valid_next  = 1'b0;
    done_next   = 1'b0;

    if (enable) begin
      if (mode != mode_q_reg) begin
        // A mode change spends one idle edge restarting the sweep state.
        mode_q_next = mode;
        cnt_next    = '0;
        ptr_next    = '0;
      end else if (!mode) begin
        cnt_next = '0;
        ptr_next = '0;
        if ({1'b0, sel} < CHAN_LIM) begin
          data_next  = chan[sel];
          ch_next    = sel;
          valid_next = 1'b1;
        end
      end else if (cnt_reg == CNT_MAX) begin
        data_next  = chan[ptr_reg];
        ch_next    = ptr_reg;
        valid_next = 1'b1;
        cnt_next   = '0;
        if (ptr_reg == PTR_MAX) begin
          ptr_next  = '0;
          done_next = 1'b1;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // State and output registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      mode_q_reg <= 1'b0;
      data_reg   <= '0;
      ch_reg     <= '0;
      valid_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      mode_q_reg <= mode_q_next;
      data_reg   <= data_next;
      ch_reg     <= ch_next;
      valid_reg  <= valid_next;
      done_reg   <= done_next;
    end
  end

  assign data_out  = data_reg;
  assign ch_out    = ch_reg;
  assign valid     = valid_reg;
  assign scan_done = done_reg;

endmodule
